// File: rtl/grid_pkg.sv
// Shared types, constants and the cell indexing helper for the grid engine.
package grid_pkg;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   // Wide enough for the largest legal grid (8 lines).
   localparam int IDX_MAX_W = 3;

   typedef enum logic [1:0] {
      PLAY     = 2'd0,
      SCRAMBLE = 2'd1,
      WON      = 2'd2
   } grid_state_t;

   typedef struct packed {
      logic [IDX_MAX_W-1:0] idx;
      logic                 n_row;
      logic                 dir;
   } grid_op_t;

   function automatic int cell_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction

endpackage

// File: rtl/grid_engine_if.sv
// Front-end/engine bundle for grid_engine; UNDO_LAST_EN adds the undo level.
interface grid_engine_if
   import grid_pkg::*;
#(
   parameter int GRID_N = 4,
   parameter int CELL_W = 2,
   parameter int MOVE_W = 16
) ();

   // All requests are levels sampled on clk and acted on at their rising edge.
   // There is no valid/ready: the engine never stalls the front end, it simply
   // drops requests it cannot take (busy high, win high, or sel_error high).
   logic                             fire;
   logic [GRID_N-1:0]                sel;
   logic                             n_row;
   logic                             add_n;
   logic                             scramble_req;
`ifdef UNDO_LAST_EN
   logic                             undo;
`endif
   logic [GRID_N*GRID_N*CELL_W-1:0]  cells_out;
   logic                             busy;
   logic                             win;
   logic                             sel_error;
   logic [MOVE_W-1:0]                move_count;
   grid_state_t                      state_dbg;

   modport master (
      output fire, sel, n_row, add_n, scramble_req,
`ifdef UNDO_LAST_EN
      output undo,
`endif
      input  cells_out, busy, win, sel_error, move_count, state_dbg
   );

   modport slave (
      input  fire, sel, n_row, add_n, scramble_req,
`ifdef UNDO_LAST_EN
      input  undo,
`endif
      output cells_out, busy, win, sel_error, move_count, state_dbg
   );

endinterface

// File: rtl/grid_lfsr.sv
// 16-bit right-shifting Galois LFSR with reset seed and step enable.
module grid_lfsr
   import grid_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic [LFSR_W-1:0] lfsr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= SEED;
      end else if (en) begin
         lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
      end
   end

endmodule

// File: rtl/grid_engine.sv
// N x N puzzle grid: row/column +-1 moves, LFSR scramble, move count, win flag.
// Optional single-level undo of the last user move when UNDO_LAST_EN is defined.
module grid_engine
   import grid_pkg::*;
#(
   parameter int                GRID_N         = 4,
   parameter int                CELL_W         = 2,
   parameter int                MOVE_W         = 16,
   parameter int                SCRAMBLE_MOVES = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
   input  logic          clk,
   input  logic          reset,
   grid_engine_if.slave  bus
);

   localparam int NC    = GRID_N * GRID_N;
   localparam int IDX_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
   localparam int CNT_W = (SCRAMBLE_MOVES > 1) ? $clog2(SCRAMBLE_MOVES) : 1;
   localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(SCRAMBLE_MOVES - 1);

   grid_state_t              state;
   logic [NC*CELL_W-1:0]     cells_q;
   logic [NC*CELL_W-1:0]     cells_nxt;
   logic [MOVE_W-1:0]        move_q;
   logic                     win_q;
   logic                     busy_q;
   logic                     moved_q;
   logic                     fire_q;
   logic                     scr_q;
   logic [CNT_W-1:0]         scr_cnt;
   logic [LFSR_W-1:0]        lfsr;
   logic                     unused_lfsr;

   logic                     fire_rise;
   logic                     scr_rise;
   logic                     sel_error;
   logic [IDX_MAX_W-1:0]     sel_idx;
   logic                     all_eq;
   logic                     win_cond;
   logic                     op_en;
   logic                     user_op;
   logic                     undo_op;
   grid_op_t                 op;
   logic [CELL_W-1:0]        cur;

`ifdef UNDO_LAST_EN
   logic                     undo_q;
   logic                     undo_rise;
   grid_op_t                 last_op;
   logic                     last_valid;
   assign undo_rise = bus.undo & ~undo_q;
`endif

   grid_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .lfsr  (lfsr)
   );

   // Only a few LFSR bits steer the scramble; the rest just feed the sequence.
   assign unused_lfsr = ^lfsr;

   assign fire_rise = bus.fire & ~fire_q;
   assign scr_rise  = bus.scramble_req & ~scr_q;
   assign sel_error = !$onehot(bus.sel);

   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < GRID_N; k++) begin
         if (bus.sel[k]) sel_idx = IDX_MAX_W'(k);
      end
   end

   always_comb begin
      all_eq = 1'b1;
      for (int k = 1; k < NC; k++) begin
         if (cells_q[k*CELL_W +: CELL_W] != cells_q[CELL_W-1:0]) all_eq = 1'b0;
      end
   end

   assign win_cond = moved_q & all_eq;

   // Scramble outranks the win test, which outranks a user move, which outranks undo.
   always_comb begin
      op_en   = 1'b0;
      user_op = 1'b0;
      undo_op = 1'b0;
      op      = '0;
      case (state)
         SCRAMBLE: begin
            op_en    = 1'b1;
            op.idx   = IDX_MAX_W'(lfsr[IDX_W-1:0]);
            op.n_row = lfsr[8];
            op.dir   = lfsr[9];
         end
         PLAY: begin
            if (!scr_rise && !win_cond) begin
               if (fire_rise && !sel_error) begin
                  user_op  = 1'b1;
                  op_en    = 1'b1;
                  op.idx   = sel_idx;
                  op.n_row = bus.n_row;
                  op.dir   = bus.add_n;
               end
`ifdef UNDO_LAST_EN
               else if (!fire_rise && undo_rise && last_valid) begin
                  undo_op  = 1'b1;
                  op_en    = 1'b1;
                  op.idx   = last_op.idx;
                  op.n_row = last_op.n_row;
                  op.dir   = ~last_op.dir;
               end
`endif
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      cells_nxt = cells_q;
      cur       = '0;
      if (op_en) begin
         for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
               if (op.n_row ? (op.idx == IDX_MAX_W'(c)) : (op.idx == IDX_MAX_W'(r))) begin
                  cur = cells_q[cell_idx(r, c, GRID_N)*CELL_W +: CELL_W];
                  cells_nxt[cell_idx(r, c, GRID_N)*CELL_W +: CELL_W] =
                     op.dir ? cur - 1'b1 : cur + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PLAY;
         cells_q    <= '0;
         move_q     <= '0;
         win_q      <= 1'b0;
         busy_q     <= 1'b0;
         moved_q    <= 1'b0;
         fire_q     <= 1'b0;
         scr_q      <= 1'b0;
         scr_cnt    <= '0;
`ifdef UNDO_LAST_EN
         undo_q     <= 1'b0;
         last_op    <= '0;
         last_valid <= 1'b0;
`endif
      end else begin
         fire_q  <= bus.fire;
         scr_q   <= bus.scramble_req;
         cells_q <= cells_nxt;
`ifdef UNDO_LAST_EN
         undo_q  <= bus.undo;
`endif
         case (state)
            PLAY: begin
               if (scr_rise) begin
                  state   <= SCRAMBLE;
                  busy_q  <= 1'b1;
                  scr_cnt <= '0;
`ifdef UNDO_LAST_EN
                  last_valid <= 1'b0;
`endif
               end else if (win_cond) begin
                  state <= WON;
                  win_q <= 1'b1;
`ifdef UNDO_LAST_EN
                  last_valid <= 1'b0;
`endif
               end else if (user_op) begin
                  if (move_q != '1) move_q <= move_q + 1'b1;
                  moved_q <= 1'b1;
`ifdef UNDO_LAST_EN
                  last_op    <= op;
                  last_valid <= 1'b1;
`endif
               end else if (undo_op) begin
                  if (move_q != '0) move_q <= move_q - 1'b1;
`ifdef UNDO_LAST_EN
                  last_valid <= 1'b0;
`endif
               end
            end
            SCRAMBLE: begin
               if (scr_cnt == LAST_OP) begin
                  state   <= PLAY;
                  busy_q  <= 1'b0;
                  move_q  <= '0;
                  moved_q <= 1'b0;
               end else begin
                  scr_cnt <= scr_cnt + 1'b1;
               end
            end
            WON: begin
               if (scr_rise) begin
                  state   <= SCRAMBLE;
                  win_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  scr_cnt <= '0;
               end
            end
            default: state <= PLAY;
         endcase
      end
   end

   assign bus.cells_out  = cells_q;
   assign bus.busy       = busy_q;
   assign bus.win        = win_q;
   assign bus.sel_error  = sel_error;
   assign bus.move_count = move_q;
   assign bus.state_dbg  = state;

endmodule
